// File: rtl/wave_scan_ctrl.sv
// wave_scan_ctrl: display-side read sequencer for the
// 5-bank waveform persistence RAM (one scan per episode).
module wave_scan_ctrl #(
  parameter logic [10:0] WIN_X  = 11'd160,
  parameter logic [10:0] WIN_Y  = 11'd112,
  parameter int          WIN_W  = 320,
  parameter int          WIN_H  = 256,
  parameter int          RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_vs,
  input  logic        vid_de,
  input  logic        db_show,
  output logic [13:0] raddr_out,
  output logic [4:0]  rden_out,
  output logic        frame_de_out,
  output logic        pix_valid,
  output logic        pix_in_win,
  output logic        scan_busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE, WAIT_VS, SCAN, RELEASE, HOLD
  } state_t;

  state_t state, state_n;

  logic [10:0] h_cnt, v_cnt;
  logic        de_d;
  logic        de_fall;
  logic [11:0] hx, vy;
  logic [11:0] x_lo, x_hi, y_lo, y_hi;
  logic        in_win;
  logic        last_line;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [7:0]  row;
  logic [4:0]  rd_n;
  logic [RD_LAT:0] pv_sr, pw_sr;

  assign de_fall = de_d && !vid_de;

  // 12-bit compare keeps WIN_X+WIN_W from wrapping
  assign hx   = {1'b0, h_cnt};
  assign vy   = {1'b0, v_cnt};
  assign x_lo = {1'b0, WIN_X};
  assign x_hi = x_lo + 12'(WIN_W);
  assign y_lo = {1'b0, WIN_Y};
  assign y_hi = y_lo + 12'(WIN_H);

  assign in_win = vid_de
               && hx >= x_lo && hx < x_hi
               && vy >= y_lo && vy < y_hi;

  assign last_line = de_fall
    && (v_cnt == WIN_Y + 11'(WIN_H - 1));

  assign x   = 9'(h_cnt - WIN_X);
  assign y   = 8'(v_cnt - WIN_Y);
  // top line of the window shows the highest code
  assign row = 8'd255 - y;

  assign rd_n = (state == SCAN && in_win)
              ? (5'd1 << x[8:6]) : 5'd0;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (db_show) state_n = WAIT_VS;
      WAIT_VS: begin
        if (!db_show)    state_n = IDLE;
        else if (vid_vs) state_n = SCAN;
      end
      SCAN:    if (last_line || vid_vs)
                 state_n = RELEASE;
      RELEASE: state_n = HOLD;
      HOLD:    if (!db_show) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      de_d         <= 1'b0;
      raddr_out    <= '0;
      rden_out     <= '0;
      pv_sr        <= '0;
      pw_sr        <= '0;
      frame_de_out <= 1'b0;
      scan_busy    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      de_d <= vid_de;
      if (vid_de) h_cnt <= h_cnt + 11'd1;
      else        h_cnt <= '0;
      if (vid_vs)       v_cnt <= '0;
      else if (de_fall) v_cnt <= v_cnt + 11'd1;
      rden_out <= rd_n;
      if (rd_n != 5'd0)
        raddr_out <= {row, x[5:0]};
      pv_sr <= {pv_sr[RD_LAT-1:0], vid_de};
      pw_sr <= {pw_sr[RD_LAT-1:0], in_win};
      frame_de_out <= (state_n == SCAN);
      frame_done   <= (state_n == RELEASE);
      scan_busy    <= (state_n == WAIT_VS)
                   || (state_n == SCAN);
    end
  end

  assign pix_valid  = pv_sr[RD_LAT];
  assign pix_in_win = pw_sr[RD_LAT];

endmodule
